// File: rtl/byte_shift_reader.sv
// byte_shift_reader: parallel-in, serial-out frame reader with valid strobe and done pulse.
// Optional PARITY_EN appends an even-parity bit after the payload.
module byte_shift_reader #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);
`ifdef PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 2);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_nxt;
   logic [N-1:0] sh, sh_nxt, frame;
   logic [CW-1:0] cnt, cnt_nxt;
   logic head_nxt;
   // parity sits on the far end of the register so it leaves right after the payload
`ifdef PARITY_EN
   assign frame = MSB_FIRST ? {din, ^din} : {^din, din};
`else
   assign frame = din;
`endif
   assign head_nxt = MSB_FIRST ? sh_nxt[N-1] : sh_nxt[0];
   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (ld) begin
            state_nxt = SHIFT;
            sh_nxt    = frame;
            cnt_nxt   = CW'(N);
         end
         SHIFT: begin
            sh_nxt    = MSB_FIRST ? sh << 1 : sh >> 1;
            cnt_nxt   = cnt - CW'(1);
            state_nxt = (cnt == CW'(1)) ? DONE : SHIFT;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sh         <= '0;
         cnt        <= '0;
         ready      <= 1'b1;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         sh         <= sh_nxt;
         cnt        <= cnt_nxt;
         ready      <= state_nxt == IDLE;
         sout       <= (state_nxt == SHIFT) && head_nxt;
         sout_valid <= state_nxt == SHIFT;
         done       <= state_nxt == DONE;
      end
   end
endmodule

// File: tb/tb_byte_shift_reader.sv
// tb_byte_shift_reader: directed checks of an MSB-first and an LSB-first instance driven in parallel.
module tb_byte_shift_reader;
`ifdef PARITY_EN
   localparam int NP = 9;
`else
   localparam int NP = 8;
`endif
   logic clk = 1'b0, rst = 1'b1, ld = 1'b0;
   logic [7:0] din = 8'h00;
   logic ready_m, sout_m, valid_m, done_m;
   logic ready_l, sout_l, valid_l, done_l;
   int checks = 0, errors = 0;
   time t_acc = 0, t_prev = 0;
   always #5 clk = ~clk;
   byte_shift_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .ld(ld), .din(din),
      .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m));
   byte_shift_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .ld(ld), .din(din),
      .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic exp_bit(input logic [7:0] d, input bit msb, input int i);
      return (i == 8) ? ^d : (msb ? d[7-i] : d[i]);
   endfunction
   task automatic check_idle(input string tag);
      check({tag, "_rdy"}, {ready_m, ready_l}, 2'b11);
      check({tag, "_vld"}, {valid_m, valid_l}, 2'b00);
      check({tag, "_sout"}, {sout_m, sout_l}, 2'b00);
      check({tag, "_done"}, {done_m, done_l}, 2'b00);
   endtask
   // called at a negedge in an IDLE cycle; returns at the negedge of the ready cycle after done
   task automatic run_frame(input logic [7:0] d, input bit hold, input int busy_at);
      check("rdy_acc", {ready_m, ready_l}, 2'b11);
      ld = 1'b1;
      din = d;
      @(posedge clk);
      t_prev = t_acc;
      t_acc = $time;
      @(negedge clk);
      if (!hold) ld = 1'b0;
      for (int i = 0; i < NP; i++) begin
         check("vld", {valid_m, valid_l}, 2'b11);
         check("rdy_busy", {ready_m, ready_l}, 2'b00);
         check("done_busy", {done_m, done_l}, 2'b00);
         check("sout_m", sout_m, exp_bit(d, 1'b1, i));
         check("sout_l", sout_l, exp_bit(d, 1'b0, i));
         if (i == busy_at) begin
            ld = 1'b1;
            din = 8'hFF;
         end
         if (i == busy_at + 3) ld = 1'b0;
         @(negedge clk);
      end
      check("done", {done_m, done_l}, 2'b11);
      check("vld_done", {valid_m, valid_l}, 2'b00);
      check("sout_done", {sout_m, sout_l}, 2'b00);
      check("rdy_done", {ready_m, ready_l}, 2'b00);
      @(negedge clk);
      check("rdy_back", {ready_m, ready_l}, 2'b11);
      check("done_back", {done_m, done_l}, 2'b00);
      check("vld_back", {valid_m, valid_l}, 2'b00);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_idle("reset");
         @(negedge clk);
      end
      run_frame(8'hA5, 1'b0, -1);
      run_frame(8'h07, 1'b0, -1);
      // ld with new data while busy must be ignored and not queued
      run_frame(8'h00, 1'b0, 2);
      for (int k = 0; k < 2; k++) begin
         check_idle("no_queue");
         @(negedge clk);
      end
      // reset mid-frame discards the frame without a done pulse
      ld = 1'b1;
      din = 8'hC3;
      @(posedge clk);
      @(negedge clk);
      ld = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_vld", {valid_m, valid_l}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("mid_rst");
      @(negedge clk);
      check_idle("post_rst");
      run_frame(8'h96, 1'b0, -1);
      // ld held high: frames start NP+2 cycles apart
      run_frame(8'h3C, 1'b1, -1);
      run_frame(8'h3C, 1'b1, -1);
      check("b2b_gap", 32'(t_acc - t_prev), 32'((NP + 2) * 10));
      run_frame(8'h3C, 1'b0, -1);
      check("b2b_gap2", 32'(t_acc - t_prev), 32'((NP + 2) * 10));
      check_idle("end");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/byte_shift_reader.md
# byte_shift_reader

Parallel-in, serial-out reader for the byte storage path. It captures a WIDTH-bit word from a byte register on a load handshake and shifts it out one bit per clock with a valid strobe, then pulses a completion flag. It sits between the write-enabled byte registers and any serial consumer, and forms the read/transmit end of that path.

## Interface

- WIDTH, 8, data word width in bits; legal range 2–32
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- ld  input  1  load request; accepted only when ready=1
- din  input  WIDTH  parallel word; sampled on the accepting edge
- ready  output  1  block idle and able to accept ld
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a payload or parity bit this cycle
- done  output  1  one-cycle pulse after the final bit

## Operation

- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - ready=1, sout_valid=0, done=0, sout=0.
  - When ld=1, din goes into the shift register, the bit counter loads the frame length N, and the state moves to SHIFT.
- SHIFT:
  - ready=0, sout_valid=1, and sout is the current head bit.
  - Each cycle the register shifts toward the output, left if MSB_FIRST=1 and right otherwise, with zero fill, and the counter decrements.
  - When the counter reaches 1, the state moves to DONE on the next edge.
- DONE: ready=0, sout_valid=0, done=1, sout=0. Lasts one cycle, then returns to IDLE.
- Frame length N = WIDTH without parity, WIDTH+1 with parity. The counter width is clog2(WIDTH+2).
- ld is ignored whenever ready=0. It is not queued.
- din is sampled only on the accepting edge. Later changes to din do not affect the frame in flight.
- Reset:
  - rst=1 wins over all other inputs, including mid-frame.
  - On the next edge: state=IDLE, shift register=0, counter=0, ready=1, sout=0, sout_valid=0, done=0.
  - Any partial frame is discarded, and done is not pulsed for it.

## Timing

- Edge E accepts ld (ld=1 and ready=1). Cycles E+1 through E+N have sout_valid=1. Edge E+N+1 gives done=1. Edge E+N+2 gives ready=1.
- The minimum ld-to-ld spacing for back-to-back frames is N+2 cycles. An ld held high continuously is accepted on the first cycle ready=1 reappears.
- ready deasserts in the cycle after acceptance. No combinational path runs from ld to ready.
- sout and sout_valid change only on clock edges. sout_valid never has gaps within a frame.
- Between frames sout_valid=0 for exactly 2 cycles: DONE plus the IDLE accept cycle.

## Configuration

- PARITY_EN:
  - When defined, an even-parity bit (XOR of all WIDTH captured bits) is computed at acceptance and shifted out as bit N = WIDTH+1, directly after the last payload bit, with sout_valid=1.
  - All timing uses N = WIDTH+1.
- When PARITY_EN is undefined, no parity logic is generated and N = WIDTH.

## Test plan

- Reset, then idle: hold rst=1 for 2 cycles, release → ready=1, sout=0, sout_valid=0, done=0, with outputs unchanged while ld=0.
- MSB-first frame (WIDTH=8, MSB_FIRST=1, no parity): ld with din=8'hA5 → sout_valid=1 for 8 cycles with sout = 1,0,1,0,0,1,0,1; done=1 on the 9th cycle after the accept edge; ready=1 on the 10th.
- LSB-first frame with parity (MSB_FIRST=0, PARITY_EN defined): din=8'h07 → sout = 1,1,1,0,0,0,0,0, then parity bit 1; 9 valid cycles, then done.
- ld while busy: ld=1 with din=8'hFF at cycle 3 of an 8'h00 frame → the 8'h00 frame completes unchanged and 8'hFF is not transmitted unless ld is still high when ready returns.
- Reset mid-frame: rst=1 at cycle 4 of the frame → the next edge gives ready=1, sout_valid=0, done=0; a fresh ld then produces a complete 8-bit frame.
- Back-to-back: ld held high with din=8'h3C → frames start exactly N+2 cycles apart, each with an identical bit pattern and one done pulse per frame.
